cpu_controller: RTL and testbench
=================================

# cpu_controller

Control stage that sits directly upstream of `datapath` and drives every one of its control inputs. It owns:
- the instruction register (IR), the 9-bit program counter and the data-address register;
- the instruction decoder;
- the fetch/decode/execute state machine.

It issues fetch, load and store commands to memory and runs one instruction at a time until HALT.

## Interface
Parameters:
- `ADDR_W`, default 9: width of `PC` and `mem_addr`.

Ports:
- `clk`  in  1  rising-edge clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `read_data`  in  16  memory read data; captured into IR on fetch.
- `C`  in  16  datapath `out`; used as load/store address.
- `mem_cmd`  out  2  00 NONE, 01 READ, 10 WRITE.
- `mem_addr`  out  ADDR_W  memory address. Carries `PC` during fetch, else the data-address register.
- `PC`  out  ADDR_W  program counter, to datapath.
- `sximm8`, `sximm5`  out  16  sign-extended IR[7:0] and IR[4:0].
- `vsel`  out  4  one-hot: 0001 C, 0010 PC, 0100 sximm8, 1000 mdata.
- `asel`  out  2  00 A, 01 zero, 10 PC.
- `bsel`  out  2  00 shifter, 01 sximm5, 10 sximm8.
- `shift`, `ALUop`  out  2 each  IR[4:3] and IR[12:11].
- `readnum`, `writenum`  out  3 each  register index selected from Rn, Rd or Rm.
- `write`, `loada`, `loadb`, `loadc`, `loads`  out  1 each  datapath enables.
- `halted`  out  1  high while in HALT.

## Operation
IR fields:
- opcode = IR[15:13], op = IR[12:11];
- Rn = IR[10:8], Rd = IR[7:5], Rm = IR[2:0].

Fetch sequence (every instruction):
- IF1: `mem_cmd`=READ, `mem_addr`=PC.
- IF2: same outputs; IR loads `read_data` at the end of the cycle.
- UPD_PC: PC ← PC+1 (wraps modulo 2^ADDR_W).
- DECODE: dispatch on {opcode, op}.

Execute sequences:
- MOV Rn,#im8 (110/10): WR_IMM. vsel=0100, writenum=Rn, write=1.
- MOV Rd,Rm,sh (110/00): GET_B (readnum=Rm, loadb), then ALU (asel=01, bsel=00, ALUop=00, loadc), then WR_C (vsel=0001, writenum=Rd, write).
- MVN (101/11): same as MOV Rd,Rm,sh with ALUop=11.
- ADD/AND (101/00, 101/10): GET_A (readnum=Rn, loada), then GET_B, ALU, WR_C.
- CMP (101/01): GET_A, GET_B, then ALU with loads=1 and loadc=0. No write-back.
- LDR (011/00):
  - GET_A, then ADDR (asel=00, bsel=01, ALUop=00, loadc), then LD_ADDR (data-addr ← C[ADDR_W-1:0]);
  - MEM_RD (mem_cmd=READ), then MEM_WB (mem_cmd=READ held, vsel=1000, writenum=Rd, write).
- STR (100/00):
  - GET_A, ADDR, LD_ADDR;
  - GET_B with readnum=Rd, then MOVE_B (asel=01, bsel=00, loadc);
  - MEM_WR (mem_cmd=WRITE).
- HALT (111/xx): HALT state is absorbing; `halted`=1.
- Any other encoding: treated as HALT.

After the last execute state, the machine returns to IF1.

## Timing
- Reset assertion is asynchronous and wins over everything, including mid-instruction.
- Reset values: state=RST; PC=0; IR=0; data-addr=0; all enables 0; `mem_cmd`=NONE; `vsel`=0001; `asel`=`bsel`=00; `halted`=0.
- After deassertion: one RST cycle, then IF1 on the next edge.
- All outputs are decoded from the registered state and IR (Moore). There is no combinational path from `read_data` or `C`.
- Cycle counts from IF1 to the next IF1:
  - MOV-imm 5; MOV-reg and MVN 7; ADD and AND 8; CMP 7;
  - LDR 9; STR 10.
- Memory read latency: `read_data` is valid in the second consecutive cycle of READ. IR and the load write-back rely on this.
- Only one of `loada`, `loadb`, `loadc`, `write` is active per cycle, except `loads` alongside CMP's ALU state.

## Structure
- Package `cpu_pkg`: state enum, opcode/op constants, `mem_cmd` codes, one-hot `vsel` constants, `asel`/`bsel` codes.
- Sub-module `instr_dec`: combinational IR field extraction, sign extension, and readnum/writenum mux driven by a 3-bit one-hot `nsel` (Rn/Rd/Rm).
- Top level holds the FSM, IR, PC and data-address register.

## Test plan
- Reset: hold `reset_n`=0 with `clk` toggling, then release. PC=0, `mem_cmd` NONE for 1 cycle, then READ at address 0. Assert `reset_n`=0 during ALU of an ADD → outputs return to reset values immediately (before the next edge).
- Memory 0xD007, 0xD102, 0xA041, 0xE000 → R0=7, R1=2, R2=9. `halted` rises 5+5+8+4=22 cycles after IF1 of address 0. PC=4 and holds.
- CMP 0xA801 after R0=R1=2 → `loads`=1 exactly one cycle; Z=1; no `write` pulse.
- LDR 0x6061 with R0=4, mem[5]=0xBEEF → `mem_addr`=5 in MEM_RD and MEM_WB; R3=0xBEEF; 9 cycles.
- STR 0x8040 with R0=6, R2=0x1234 → MEM_WR: `mem_cmd`=10, `mem_addr`=6, C=0x1234.
- PC wrap: start fetch at PC=511 with ADDR_W=9 → after UPD_PC, PC=0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared types and encodings for the cpu_controller block: FSM states,
// opcode/op fields, memory command codes, datapath select codes and an
// instruction classifier used by the decode dispatch.
package cpu_pkg;

  localparam int unsigned WORD_W    = 16;
  localparam int unsigned REG_IDX_W = 3;

  typedef enum logic [4:0] {
    S_RST,
    S_IF1,
    S_IF2,
    S_UPD_PC,
    S_DECODE,
    S_WR_IMM,
    S_GET_A,
    S_GET_B,
    S_ALU,
    S_WR_C,
    S_ADDR,
    S_LD_ADDR,
    S_MEM_RD,
    S_MEM_WB,
    S_MOVE_B,
    S_MEM_WR,
    S_HALT
  } state_t;

  // Execute-sequence families; several encodings share one sequence.
  typedef enum logic [2:0] {
    INS_MOV_IMM,
    INS_SHIFT,    // MOV Rd,Rm,sh and MVN: B operand only
    INS_ALU,      // ADD, AND: both operands, write-back
    INS_CMP,
    INS_LDR,
    INS_STR,
    INS_HALT
  } ins_t;

  localparam logic [2:0] OPC_LDR  = 3'b011;
  localparam logic [2:0] OPC_STR  = 3'b100;
  localparam logic [2:0] OPC_ALU  = 3'b101;
  localparam logic [2:0] OPC_MOV  = 3'b110;
  localparam logic [2:0] OPC_HALT = 3'b111;

  localparam logic [1:0] OP_MOV_REG = 2'b00;
  localparam logic [1:0] OP_MOV_IMM = 2'b10;
  localparam logic [1:0] OP_ADD     = 2'b00;
  localparam logic [1:0] OP_CMP     = 2'b01;
  localparam logic [1:0] OP_AND     = 2'b10;
  localparam logic [1:0] OP_MVN     = 2'b11;
  localparam logic [1:0] OP_MEM     = 2'b00;

  localparam logic [1:0] MEM_NONE  = 2'b00;
  localparam logic [1:0] MEM_READ  = 2'b01;
  localparam logic [1:0] MEM_WRITE = 2'b10;

  localparam logic [3:0] VSEL_C     = 4'b0001;
  localparam logic [3:0] VSEL_PC    = 4'b0010;
  localparam logic [3:0] VSEL_IMM8  = 4'b0100;
  localparam logic [3:0] VSEL_MDATA = 4'b1000;

  localparam logic [1:0] ASEL_A    = 2'b00;
  localparam logic [1:0] ASEL_ZERO = 2'b01;
  localparam logic [1:0] ASEL_PC   = 2'b10;

  localparam logic [1:0] BSEL_SHIFT = 2'b00;
  localparam logic [1:0] BSEL_IMM5  = 2'b01;
  localparam logic [1:0] BSEL_IMM8  = 2'b10;

  localparam logic [2:0] NSEL_NONE = 3'b000;
  localparam logic [2:0] NSEL_RN   = 3'b001;
  localparam logic [2:0] NSEL_RD   = 3'b010;
  localparam logic [2:0] NSEL_RM   = 3'b100;

  // Map {opcode, op} to its execute family; unknown encodings halt.
  function automatic ins_t classify(input logic [2:0] opcode, input logic [1:0] op);
    ins_t cls;
    cls = INS_HALT;
    case (opcode)
      OPC_MOV: begin
        if (op == OP_MOV_IMM)      cls = INS_MOV_IMM;
        else if (op == OP_MOV_REG) cls = INS_SHIFT;
      end
      OPC_ALU: begin
        case (op)
          OP_ADD, OP_AND: cls = INS_ALU;
          OP_CMP:         cls = INS_CMP;
          default:        cls = INS_SHIFT;  // MVN
        endcase
      end
      OPC_LDR: if (op == OP_MEM) cls = INS_LDR;
      OPC_STR: if (op == OP_MEM) cls = INS_STR;
      default: cls = INS_HALT;
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/instr_dec.sv
// Combinational instruction decoder.
// Ports: ir (instruction register) and nsel (one-hot Rn/Rd/Rm select) in;
// opcode/op fields, sign-extended immediates, shift and ALU op fields, and
// the selected register index out.
module instr_dec
  import cpu_pkg::*;
(
  input  logic [WORD_W-1:0]    ir,
  input  logic [2:0]           nsel,
  output logic [2:0]           opcode,
  output logic [1:0]           op,
  output logic [WORD_W-1:0]    sximm8,
  output logic [WORD_W-1:0]    sximm5,
  output logic [1:0]           shift,
  output logic [1:0]           alu_op,
  output logic [REG_IDX_W-1:0] reg_num
);

  logic [REG_IDX_W-1:0] rn;
  logic [REG_IDX_W-1:0] rd;
  logic [REG_IDX_W-1:0] rm;

  assign opcode = ir[15:13];
  assign op     = ir[12:11];
  assign rn     = ir[10:8];
  assign rd     = ir[7:5];
  assign rm     = ir[2:0];
  assign shift  = ir[4:3];
  assign alu_op = ir[12:11];

  assign sximm8 = {{(WORD_W-8){ir[7]}}, ir[7:0]};
  assign sximm5 = {{(WORD_W-5){ir[4]}}, ir[4:0]};

  // One-hot AND-OR mux; an all-zero select yields register 0.
  assign reg_num = ({REG_IDX_W{nsel[0]}} & rn)
                 | ({REG_IDX_W{nsel[1]}} & rd)
                 | ({REG_IDX_W{nsel[2]}} & rm);

endmodule

// File: rtl/cpu_controller.sv
// Fetch/decode/execute controller driving the datapath and memory.
// Ports: clk, reset_n (async active-low); read_data (memory data) and C
// (datapath result) in; mem_cmd/mem_addr to memory; PC, immediates, operand
// selects, register indices and load/write enables to the datapath; halted.
// All outputs are Moore-decoded from the state register and IR.
module cpu_controller
  import cpu_pkg::*;
#(
  parameter int unsigned ADDR_W = 9
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [WORD_W-1:0]    read_data,
  input  logic [WORD_W-1:0]    C,
  output logic [1:0]           mem_cmd,
  output logic [ADDR_W-1:0]    mem_addr,
  output logic [ADDR_W-1:0]    PC,
  output logic [WORD_W-1:0]    sximm8,
  output logic [WORD_W-1:0]    sximm5,
  output logic [3:0]           vsel,
  output logic [1:0]           asel,
  output logic [1:0]           bsel,
  output logic [1:0]           shift,
  output logic [1:0]           ALUop,
  output logic [REG_IDX_W-1:0] readnum,
  output logic [REG_IDX_W-1:0] writenum,
  output logic                 write,
  output logic                 loada,
  output logic                 loadb,
  output logic                 loadc,
  output logic                 loads,
  output logic                 halted
);

  state_t               state;
  state_t               state_nxt;
  logic [WORD_W-1:0]    ir;
  logic [ADDR_W-1:0]    pc;
  logic [ADDR_W-1:0]    data_addr;
  logic                 load_ir;
  logic                 inc_pc;
  logic                 load_addr;
  logic                 fetch;
  logic [2:0]           nsel;
  logic [2:0]           opcode;
  logic [1:0]           op;
  logic [REG_IDX_W-1:0] reg_num;
  ins_t                 cls;
  logic                 unused_c;

  // Only the low ADDR_W bits of C form an address.
  assign unused_c = ^C;

  instr_dec u_dec (
    .ir      (ir),
    .nsel    (nsel),
    .opcode  (opcode),
    .op      (op),
    .sximm8  (sximm8),
    .sximm5  (sximm5),
    .shift   (shift),
    .alu_op  (ALUop),
    .reg_num (reg_num)
  );

  assign cls      = classify(opcode, op);
  assign readnum  = reg_num;
  assign writenum = reg_num;
  assign PC       = pc;
  assign mem_addr = fetch ? pc : data_addr;

  // State, IR, PC and data-address registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_RST;
      ir        <= '0;
      pc        <= '0;
      data_addr <= '0;
    end else begin
      state <= state_nxt;
      if (load_ir)   ir        <= read_data;
      if (inc_pc)    pc        <= pc + ADDR_W'(1);
      if (load_addr) data_addr <= C[ADDR_W-1:0];
    end
  end

  // Next-state and output decode.
  always_comb begin
    state_nxt = state;
    mem_cmd   = MEM_NONE;
    fetch     = 1'b0;
    vsel      = VSEL_C;
    asel      = ASEL_A;
    bsel      = BSEL_SHIFT;
    nsel      = NSEL_NONE;
    write     = 1'b0;
    loada     = 1'b0;
    loadb     = 1'b0;
    loadc     = 1'b0;
    loads     = 1'b0;
    halted    = 1'b0;
    load_ir   = 1'b0;
    inc_pc    = 1'b0;
    load_addr = 1'b0;

    case (state)
      S_RST: state_nxt = S_IF1;
      S_IF1: begin
        mem_cmd   = MEM_READ;
        fetch     = 1'b1;
        state_nxt = S_IF2;
      end
      // Read data is valid in the second READ cycle; capture it here.
      S_IF2: begin
        mem_cmd   = MEM_READ;
        fetch     = 1'b1;
        load_ir   = 1'b1;
        state_nxt = S_UPD_PC;
      end
      S_UPD_PC: begin
        inc_pc    = 1'b1;
        state_nxt = S_DECODE;
      end
      S_DECODE: begin
        case (cls)
          INS_MOV_IMM:                      state_nxt = S_WR_IMM;
          INS_SHIFT:                        state_nxt = S_GET_B;
          INS_ALU, INS_CMP, INS_LDR, INS_STR: state_nxt = S_GET_A;
          default:                          state_nxt = S_HALT;
        endcase
      end
      S_WR_IMM: begin
        vsel      = VSEL_IMM8;
        nsel      = NSEL_RN;
        write     = 1'b1;
        state_nxt = S_IF1;
      end
      S_GET_A: begin
        nsel      = NSEL_RN;
        loada     = 1'b1;
        state_nxt = (cls == INS_LDR || cls == INS_STR) ? S_ADDR : S_GET_B;
      end
      // STR stores Rd; every other user of GET_B reads Rm.
      S_GET_B: begin
        nsel      = (cls == INS_STR) ? NSEL_RD : NSEL_RM;
        loadb     = 1'b1;
        state_nxt = (cls == INS_STR) ? S_MOVE_B : S_ALU;
      end
      S_ALU: begin
        asel = (cls == INS_SHIFT) ? ASEL_ZERO : ASEL_A;
        bsel = BSEL_SHIFT;
        if (cls == INS_CMP) begin
          loads     = 1'b1;
          state_nxt = S_IF1;
        end else begin
          loadc     = 1'b1;
          state_nxt = S_WR_C;
        end
      end
      S_WR_C: begin
        vsel      = VSEL_C;
        nsel      = NSEL_RD;
        write     = 1'b1;
        state_nxt = S_IF1;
      end
      S_ADDR: begin
        asel      = ASEL_A;
        bsel      = BSEL_IMM5;
        loadc     = 1'b1;
        state_nxt = S_LD_ADDR;
      end
      S_LD_ADDR: begin
        load_addr = 1'b1;
        state_nxt = (cls == INS_LDR) ? S_MEM_RD : S_GET_B;
      end
      S_MEM_RD: begin
        mem_cmd   = MEM_READ;
        state_nxt = S_MEM_WB;
      end
      S_MEM_WB: begin
        mem_cmd   = MEM_READ;
        vsel      = VSEL_MDATA;
        nsel      = NSEL_RD;
        write     = 1'b1;
        state_nxt = S_IF1;
      end
      S_MOVE_B: begin
        asel      = ASEL_ZERO;
        bsel      = BSEL_SHIFT;
        loadc     = 1'b1;
        state_nxt = S_MEM_WR;
      end
      S_MEM_WR: begin
        mem_cmd   = MEM_WRITE;
        state_nxt = S_IF1;
      end
      S_HALT: halted = 1'b1;
      default: state_nxt = S_RST;
    endcase
  end

endmodule

// File: tb/tb_cpu_controller.sv
// Directed bench: cpu_controller plus a small behavioural datapath and memory.
module tb_cpu_controller;

  logic        clk;
  logic        reset_n;
  logic [15:0] read_data;
  logic [15:0] c_reg;
  logic [1:0]  mem_cmd;
  logic [8:0]  mem_addr;
  logic [8:0]  pc;
  logic [15:0] sximm8;
  logic [15:0] sximm5;
  logic [3:0]  vsel;
  logic [1:0]  asel;
  logic [1:0]  bsel;
  logic [1:0]  shift;
  logic [1:0]  alu_op;
  logic [2:0]  readnum;
  logic [2:0]  writenum;
  logic        write;
  logic        loada;
  logic        loadb;
  logic        loadc;
  logic        loads;
  logic        halted;

  cpu_controller #(.ADDR_W(9)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .read_data (read_data),
    .C         (c_reg),
    .mem_cmd   (mem_cmd),
    .mem_addr  (mem_addr),
    .PC        (pc),
    .sximm8    (sximm8),
    .sximm5    (sximm5),
    .vsel      (vsel),
    .asel      (asel),
    .bsel      (bsel),
    .shift     (shift),
    .ALUop     (alu_op),
    .readnum   (readnum),
    .writenum  (writenum),
    .write     (write),
    .loada     (loada),
    .loadb     (loadb),
    .loadc     (loadc),
    .loads     (loads),
    .halted    (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural datapath and memory
  logic [15:0] regs [8];
  logic [15:0] mem  [512];
  logic [15:0] a_reg, b_reg;
  logic        z_flag;
  logic [15:0] sh_out, ain, bin, alu_out, wdata;

  logic        mem_we;
  logic [8:0]  mem_wa;
  logic [15:0] mem_wd;
  logic        pre_we;
  logic [2:0]  pre_idx;
  logic [15:0] pre_val;
  logic        cnt_clr;
  int          n_write, n_loads, n_multi;

  always_comb begin
    case (shift)
      2'b01:   sh_out = b_reg << 1;
      2'b10:   sh_out = b_reg >> 1;
      2'b11:   sh_out = {b_reg[15], b_reg[15:1]};
      default: sh_out = b_reg;
    endcase
    case (asel)
      2'b01:   ain = 16'h0000;
      2'b10:   ain = 16'(pc);
      default: ain = a_reg;
    endcase
    case (bsel)
      2'b01:   bin = sximm5;
      2'b10:   bin = sximm8;
      default: bin = sh_out;
    endcase
    case (alu_op)
      2'b01:   alu_out = ain - bin;
      2'b10:   alu_out = ain & bin;
      2'b11:   alu_out = ~bin;
      default: alu_out = ain + bin;
    endcase
    case (vsel)
      4'b0010: wdata = 16'(pc);
      4'b0100: wdata = sximm8;
      4'b1000: wdata = read_data;
      default: wdata = c_reg;
    endcase
  end

  always @(posedge clk) begin
    if (pre_we)     regs[pre_idx]  <= pre_val;
    else if (write) regs[writenum] <= wdata;
    if (loada) a_reg  <= regs[readnum];
    if (loadb) b_reg  <= regs[readnum];
    if (loadc) c_reg  <= alu_out;
    if (loads) z_flag <= (alu_out == 16'h0000);
    if (mem_we)                mem[mem_wa]   <= mem_wd;
    else if (mem_cmd == 2'b10) mem[mem_addr] <= c_reg;
    if (mem_cmd == 2'b01) read_data <= mem[mem_addr];
  end

  // Pulse counters sampled mid-cycle
  always @(negedge clk) begin
    if (cnt_clr) begin
      n_write <= 0;
      n_loads <= 0;
      n_multi <= 0;
    end else if (reset_n) begin
      if (write) n_write <= n_write + 1;
      if (loads) n_loads <= n_loads + 1;
      if ((32'(loada) + 32'(loadb) + 32'(loadc) + 32'(write)) > 32'd1)
        n_multi <= n_multi + 1;
    end
  end

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
  endtask

  task automatic run_to(input int k);
    while (cyc < k) tick();
  endtask

  task automatic enter_reset();
    @(negedge clk);
    reset_n = 1'b0;
    cnt_clr = 1'b1;
    @(negedge clk);
    cnt_clr = 1'b0;
  endtask

  task automatic load_mem(input int a, input logic [15:0] d);
    mem_we = 1'b1;
    mem_wa = 9'(a);
    mem_wd = d;
    @(negedge clk);
    mem_we = 1'b0;
  endtask

  task automatic load_reg(input int r, input logic [15:0] d);
    pre_we  = 1'b1;
    pre_idx = 3'(r);
    pre_val = d;
    @(negedge clk);
    pre_we = 1'b0;
  endtask

  // Release on a negedge; cycle 0 is the RST cycle, cycle 1 is the first IF1.
  task automatic release_reset();
    reset_n = 1'b1;
    cyc = 0;
  endtask

  initial begin
    reset_n = 1'b0;
    mem_we  = 1'b0; mem_wa = '0; mem_wd = '0;
    pre_we  = 1'b0; pre_idx = '0; pre_val = '0;
    cnt_clr = 1'b1;
    repeat (3) @(negedge clk);
    cnt_clr = 1'b0;

    // Program 1: MOV R0,#7; MOV R1,#2; ADD R2,R0,R1; HALT
    load_mem(0, 16'hD007);
    load_mem(1, 16'hD102);
    load_mem(2, 16'hA041);
    load_mem(3, 16'hE000);
    check("rst_mem_cmd", 32'(mem_cmd), 32'h0);
    check("rst_pc",      32'(pc),      32'h0);
    check("rst_vsel",    32'(vsel),    32'h1);
    release_reset();
    check("c0_mem_cmd",  32'(mem_cmd), 32'h0);
    tick();
    check("c1_mem_cmd",  32'(mem_cmd), 32'h1);
    check("c1_mem_addr", 32'(mem_addr), 32'h0);
    run_to(22);
    check("p1_halted_early", 32'(halted), 32'h0);
    run_to(23);
    check("p1_halted", 32'(halted), 32'h1);
    run_to(30);
    check("p1_pc_hold",  32'(pc),      32'h4);
    check("p1_halt_cmd", 32'(mem_cmd), 32'h0);
    check("p1_r0", 32'(regs[0]), 32'h7);
    check("p1_r1", 32'(regs[1]), 32'h2);
    check("p1_r2", 32'(regs[2]), 32'h9);

    // Same program, reset asserted during the ADD's ALU cycle
    enter_reset();
    release_reset();
    run_to(17);
    check("mid_alu_loadc", 32'(loadc), 32'h1);
    reset_n = 1'b0;
    #1;
    check("mid_rst_loadc",   32'(loadc),   32'h0);
    check("mid_rst_mem_cmd", 32'(mem_cmd), 32'h0);
    check("mid_rst_vsel",    32'(vsel),    32'h1);
    check("mid_rst_asel",    32'(asel),    32'h0);
    check("mid_rst_pc",      32'(pc),      32'h0);

    // Program 2: MOV R0,#2; MOV R1,#2; CMP R0,R1; HALT
    enter_reset();
    load_mem(0, 16'hD002);
    load_mem(1, 16'hD102);
    load_mem(2, 16'hA801);
    load_mem(3, 16'hE000);
    release_reset();
    run_to(17);
    check("cmp_loads", 32'(loads), 32'h1);
    check("cmp_loadc", 32'(loadc), 32'h0);
    run_to(18);
    check("cmp_next_addr", 32'(mem_addr), 32'h3);
    run_to(30);
    check("cmp_loads_cnt", 32'(n_loads), 32'h1);
    check("cmp_write_cnt", 32'(n_write), 32'h2);
    check("cmp_z",         32'(z_flag),  32'h1);

    // Program 3: MOV R0,#4; LDR R3,[R0,#1]; HALT with mem[5]=0xBEEF
    enter_reset();
    load_mem(0, 16'hD004);
    load_mem(1, 16'h6061);
    load_mem(2, 16'hE000);
    load_mem(5, 16'hBEEF);
    load_reg(3, 16'h0000);
    release_reset();
    run_to(12);
    check("ldr_ldaddr_cmd", 32'(mem_cmd), 32'h0);
    run_to(13);
    check("ldr_rd_cmd",  32'(mem_cmd),  32'h1);
    check("ldr_rd_addr", 32'(mem_addr), 32'h5);
    run_to(14);
    check("ldr_wb_cmd",   32'(mem_cmd),  32'h1);
    check("ldr_wb_addr",  32'(mem_addr), 32'h5);
    check("ldr_wb_write", 32'(write),    32'h1);
    run_to(15);
    check("ldr_next_addr", 32'(mem_addr), 32'h2);
    run_to(25);
    check("ldr_r3", 32'(regs[3]), 32'hBEEF);

    // Program 4: MOV R0,#6; STR R2,[R0]; HALT with R2=0x1234
    enter_reset();
    load_mem(0, 16'hD006);
    load_mem(1, 16'h8040);
    load_mem(2, 16'hE000);
    load_mem(6, 16'h0000);
    load_reg(2, 16'h1234);
    release_reset();
    run_to(15);
    check("str_cmd",  32'(mem_cmd),  32'h2);
    check("str_addr", 32'(mem_addr), 32'h6);
    check("str_c",    32'(c_reg),    32'h1234);
    run_to(16);
    check("str_next_addr", 32'(mem_addr), 32'h2);
    run_to(25);
    check("str_mem6", 32'(mem[6]), 32'h1234);

    // Program 5: undefined encoding halts
    enter_reset();
    load_mem(0, 16'h0000);
    release_reset();
    run_to(4);
    check("undef_halted_early", 32'(halted), 32'h0);
    run_to(5);
    check("undef_halted", 32'(halted), 32'h1);

    // Program 6: 512 x MOV R0,#0 to wrap the PC
    enter_reset();
    for (int i = 0; i < 512; i++) load_mem(i, 16'hD000);
    release_reset();
    run_to(2556);
    check("wrap_pc_511",   32'(pc),       32'h1FF);
    check("wrap_addr_511", 32'(mem_addr), 32'h1FF);
    run_to(2559);
    check("wrap_pc_0", 32'(pc), 32'h0);
    run_to(2561);
    check("wrap_fetch_cmd",  32'(mem_cmd),  32'h1);
    check("wrap_fetch_addr", 32'(mem_addr), 32'h0);
    check("enable_overlap",  32'(n_multi),  32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
